// File: rtl/axil_strobe_bridge.sv
`default_nettype none
// ============================================================================
// Module : axil_strobe_bridge
// AXI-Lite slave driving a per-port strobe/ack register bus, with fair R/W
// arbitration, ack timeout and DECERR/SLVERR responses.      Rev 1.0
// ============================================================================
module axil_strobe_bridge #(
  parameter int NUM_PORTS       = 4,
  parameter int PORT_SEL_LSB    = 10,
  parameter int PORT_SEL_BITS   = 2,
  parameter int LOCAL_ADDR_BITS = 12,
  parameter int TIMEOUT         = 255
) (
  input  logic                          axilClk,
  input  logic                          axilRstN,
  input  logic [31:0]                   axilReadMaster_araddr,
  input  logic                          axilReadMaster_arvalid,
  output logic                          axilReadSlave_arready,
  output logic [31:0]                   axilReadSlave_rdata,
  output logic [1:0]                    axilReadSlave_rresp,
  output logic                          axilReadSlave_rvalid,
  input  logic                          axilReadMaster_rready,
  input  logic [31:0]                   axilWriteMaster_awaddr,
  input  logic                          axilWriteMaster_awvalid,
  output logic                          axilWriteSlave_awready,
  input  logic [31:0]                   axilWriteMaster_wdata,
  input  logic [3:0]                    axilWriteMaster_wstrb,
  input  logic                          axilWriteMaster_wvalid,
  output logic                          axilWriteSlave_wready,
  output logic [1:0]                    axilWriteSlave_bresp,
  output logic                          axilWriteSlave_bvalid,
  input  logic                          axilWriteMaster_bready,
  output logic [NUM_PORTS-1:0]          port_wstr,
  output logic [NUM_PORTS-1:0]          port_rstr,
  input  logic [NUM_PORTS-1:0]          port_wack,
  input  logic [NUM_PORTS-1:0]          port_rack,
  output logic [LOCAL_ADDR_BITS-1:0]    port_waddr,
  output logic [LOCAL_ADDR_BITS-1:0]    port_raddr,
  output logic [31:0]                   port_din,
  input  logic [32*NUM_PORTS-1:0]       port_dout,
  output logic [15:0]                   timeout_count
);

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [15:0] CNT_LAST    = 16'(TIMEOUT - 1);
  localparam logic [31:0] RDATA_TMO   = 32'hDEAD_DEAD;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_ACC = 3'd1,
    S_WR_STB = 3'd2,
    S_WR_RSP = 3'd3,
    S_RD_ACC = 3'd4,
    S_RD_STB = 3'd5,
    S_RD_RSP = 3'd6
  } state_t;

  state_t                       state_q, state_d;
  logic [1:0]                   rst_sync_q;
  logic                         last_wr_q, last_wr_d;
  logic [PORT_SEL_BITS-1:0]     idx_q, idx_d;
  logic [15:0]                  cnt_q, cnt_d;
  logic                         arready_q, arready_d;
  logic                         awready_q, awready_d;
  logic                         wready_q, wready_d;
  logic                         rvalid_q, rvalid_d;
  logic                         bvalid_q, bvalid_d;
  logic [1:0]                   rresp_q, rresp_d;
  logic [1:0]                   bresp_q, bresp_d;
  logic [31:0]                  rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]         wstr_q, wstr_d;
  logic [NUM_PORTS-1:0]         rstr_q, rstr_d;
  logic [LOCAL_ADDR_BITS-1:0]   waddr_q, waddr_d;
  logic [LOCAL_ADDR_BITS-1:0]   raddr_q, raddr_d;
  logic [31:0]                  din_q, din_d;
  logic [15:0]                  tocnt_q, tocnt_d;

  logic [PORT_SEL_BITS-1:0]     aw_idx, ar_idx;
  logic                         aw_decerr, ar_decerr;
  logic                         accept_en, wr_elig, rd_elig;
  logic [NUM_PORTS-1:0]         sel_oh;
  logic                         wack_sel, rack_sel;
  logic [31:0]                  dout_sel;
  logic                         unused_addr_bits;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [PORT_SEL_BITS-1:0] sel);
    logic [NUM_PORTS-1:0] oh;
    oh = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      oh[k] = (sel == PORT_SEL_BITS'(k));
    end
    return oh;
  endfunction

  assign aw_idx    = axilWriteMaster_awaddr[2+PORT_SEL_LSB +: PORT_SEL_BITS];
  assign ar_idx    = axilReadMaster_araddr[2+PORT_SEL_LSB +: PORT_SEL_BITS];
  assign aw_decerr = (32'(aw_idx) >= NUM_PORTS);
  assign ar_decerr = (32'(ar_idx) >= NUM_PORTS);

  // Only a subset of address bits is decoded; the rest are intentionally ignored.
  assign unused_addr_bits = ^{axilWriteMaster_awaddr, axilReadMaster_araddr};

  // New transactions are held off until the reset release has propagated.
  assign accept_en = rst_sync_q[1];
  assign wr_elig   = accept_en & axilWriteMaster_awvalid & axilWriteMaster_wvalid;
  assign rd_elig   = accept_en & axilReadMaster_arvalid;

  always_comb begin
    sel_oh   = port_onehot(idx_q);
    wack_sel = |(port_wack & sel_oh);
    rack_sel = |(port_rack & sel_oh);
    dout_sel = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (sel_oh[k]) dout_sel = port_dout[32*k +: 32];
    end
  end

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    arready_d = 1'b0;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    rvalid_d  = rvalid_q;
    bvalid_d  = bvalid_q;
    rresp_d   = rresp_q;
    bresp_d   = bresp_q;
    rdata_d   = rdata_q;
    waddr_d   = waddr_q;
    raddr_d   = raddr_q;
    din_d     = din_q;
    tocnt_d   = tocnt_q;

    case (state_q)
      S_IDLE: begin
        // last_wr_q=0 means the read was served last, so a tie goes to the write.
        if (wr_elig && (!rd_elig || !last_wr_q)) begin
          state_d   = S_WR_ACC;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          last_wr_d = 1'b1;
        end else if (rd_elig) begin
          state_d   = S_RD_ACC;
          arready_d = 1'b1;
          last_wr_d = 1'b0;
        end
      end

      S_WR_ACC: begin
        waddr_d = axilWriteMaster_awaddr[2 +: LOCAL_ADDR_BITS];
        din_d   = axilWriteMaster_wdata;
        idx_d   = aw_idx;
        cnt_d   = '0;
        if (aw_decerr) begin
          bresp_d  = RESP_DECERR;
          bvalid_d = 1'b1;
          state_d  = S_WR_RSP;
        end else if (axilWriteMaster_wstrb != 4'hF) begin
          bresp_d  = RESP_SLVERR;
          bvalid_d = 1'b1;
          state_d  = S_WR_RSP;
        end else begin
          state_d  = S_WR_STB;
        end
      end

      S_WR_STB: begin
        if (wack_sel) begin
          bresp_d  = RESP_OKAY;
          bvalid_d = 1'b1;
          state_d  = S_WR_RSP;
        end else if (cnt_q == CNT_LAST) begin
          bresp_d  = RESP_SLVERR;
          bvalid_d = 1'b1;
          state_d  = S_WR_RSP;
          tocnt_d  = (tocnt_q == 16'hFFFF) ? tocnt_q : tocnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_WR_RSP: begin
        if (axilWriteMaster_bready) begin
          bvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      S_RD_ACC: begin
        raddr_d = axilReadMaster_araddr[2 +: LOCAL_ADDR_BITS];
        idx_d   = ar_idx;
        cnt_d   = '0;
        if (ar_decerr) begin
          rresp_d  = RESP_DECERR;
          rdata_d  = '0;
          rvalid_d = 1'b1;
          state_d  = S_RD_RSP;
        end else begin
          state_d  = S_RD_STB;
        end
      end

      S_RD_STB: begin
        if (rack_sel) begin
          rresp_d  = RESP_OKAY;
          rdata_d  = dout_sel;
          rvalid_d = 1'b1;
          state_d  = S_RD_RSP;
        end else if (cnt_q == CNT_LAST) begin
          rresp_d  = RESP_SLVERR;
          rdata_d  = RDATA_TMO;
          rvalid_d = 1'b1;
          state_d  = S_RD_RSP;
          tocnt_d  = (tocnt_q == 16'hFFFF) ? tocnt_q : tocnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_RD_RSP: begin
        if (axilReadMaster_rready) begin
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes are registered copies of the upcoming STB state.
    wstr_d = (state_d == S_WR_STB) ? port_onehot(idx_d) : '0;
    rstr_d = (state_d == S_RD_STB) ? port_onehot(idx_d) : '0;
  end

  always_ff @(posedge axilClk or negedge axilRstN) begin
    if (!axilRstN) begin
      rst_sync_q <= 2'b00;
      state_q    <= S_IDLE;
      last_wr_q  <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      arready_q  <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      bresp_q    <= 2'b00;
      rdata_q    <= '0;
      wstr_q     <= '0;
      rstr_q     <= '0;
      waddr_q    <= '0;
      raddr_q    <= '0;
      din_q      <= '0;
      tocnt_q    <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
      state_q    <= state_d;
      last_wr_q  <= last_wr_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      arready_q  <= arready_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      rvalid_q   <= rvalid_d;
      bvalid_q   <= bvalid_d;
      rresp_q    <= rresp_d;
      bresp_q    <= bresp_d;
      rdata_q    <= rdata_d;
      wstr_q     <= wstr_d;
      rstr_q     <= rstr_d;
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
      din_q      <= din_d;
      tocnt_q    <= tocnt_d;
    end
  end

  assign axilReadSlave_arready  = arready_q;
  assign axilReadSlave_rdata    = rdata_q;
  assign axilReadSlave_rresp    = rresp_q;
  assign axilReadSlave_rvalid   = rvalid_q;
  assign axilWriteSlave_awready = awready_q;
  assign axilWriteSlave_wready  = wready_q;
  assign axilWriteSlave_bresp   = bresp_q;
  assign axilWriteSlave_bvalid  = bvalid_q;
  assign port_wstr              = wstr_q;
  assign port_rstr              = rstr_q;
  assign port_waddr             = waddr_q;
  assign port_raddr             = raddr_q;
  assign port_din               = din_q;
  assign timeout_count          = tocnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_strobe_bridge.sv
`default_nettype none
// ============================================================================
// Module : tb_axil_strobe_bridge
// Directed + random transactions against a transaction-level bridge model.
// ============================================================================
module tb_axil_strobe_bridge;

  localparam int NP = 3;
  localparam int T  = 255;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, rready = 1'b0, bready = 1'b0;
  logic        arready, awready, wready, rvalid, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic [NP-1:0] port_wstr, port_rstr, port_wack, port_rack;
  logic [11:0] port_waddr, port_raddr;
  logic [31:0] port_din;
  logic [32*NP-1:0] port_dout;
  logic [15:0] timeout_count;

  axil_strobe_bridge #(
    .NUM_PORTS(NP), .PORT_SEL_LSB(10), .PORT_SEL_BITS(2), .LOCAL_ADDR_BITS(12), .TIMEOUT(T)
  ) dut (
    .axilClk(clk), .axilRstN(rst_n),
    .axilReadMaster_araddr(araddr), .axilReadMaster_arvalid(arvalid),
    .axilReadSlave_arready(arready), .axilReadSlave_rdata(rdata),
    .axilReadSlave_rresp(rresp), .axilReadSlave_rvalid(rvalid),
    .axilReadMaster_rready(rready),
    .axilWriteMaster_awaddr(awaddr), .axilWriteMaster_awvalid(awvalid),
    .axilWriteSlave_awready(awready), .axilWriteMaster_wdata(wdata),
    .axilWriteMaster_wstrb(wstrb), .axilWriteMaster_wvalid(wvalid),
    .axilWriteSlave_wready(wready), .axilWriteSlave_bresp(bresp),
    .axilWriteSlave_bvalid(bvalid), .axilWriteMaster_bready(bready),
    .port_wstr(port_wstr), .port_rstr(port_rstr), .port_wack(port_wack), .port_rack(port_rack),
    .port_waddr(port_waddr), .port_raddr(port_raddr), .port_din(port_din),
    .port_dout(port_dout), .timeout_count(timeout_count)
  );

  // Downstream port models: ack on the (delay+1)-th strobe cycle, random noise when idle.
  int          dly_w [NP];
  int          dly_r [NP];
  int          hi_w  [NP];
  int          hi_r  [NP];
  logic [NP-1:0] nz_w = '0, nz_r = '0;
  logic [31:0] dout_mem [NP];

  always @(negedge clk) begin
    for (int k = 0; k < NP; k++) begin
      hi_w[k] <= port_wstr[k] ? hi_w[k] + 1 : 0;
      hi_r[k] <= port_rstr[k] ? hi_r[k] + 1 : 0;
      nz_w[k] <= ($urandom_range(0, 3) == 0);
      nz_r[k] <= ($urandom_range(0, 3) == 0);
    end
  end

  always_comb begin
    port_wack = '0;
    port_rack = '0;
    port_dout = '0;
    for (int k = 0; k < NP; k++) begin
      port_wack[k] = port_wstr[k] ? (hi_w[k] == dly_w[k] + 1) : nz_w[k];
      port_rack[k] = port_rstr[k] ? (hi_r[k] == dly_r[k] + 1) : nz_r[k];
      port_dout[32*k +: 32] = dout_mem[k];
    end
  end

  // Strobe monitor: counts cycles matching / not matching the expected strobe pattern.
  logic [NP-1:0] exp_w = '0, exp_r = '0;
  int stb_good = 0, stb_bad = 0;
  always @(negedge clk) begin
    if ((port_wstr | port_rstr) != '0) begin
      if (port_wstr == exp_w && port_rstr == exp_r) stb_good <= stb_good + 1;
      else stb_bad <= stb_bad + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0, n_fail = 0;
  int exp_to = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int dly, input int hold);
    int idx, g0, b0, n, t0, lat_exp, stb_exp;
    logic [1:0] resp_exp, r0;
    logic stable;
    idx = int'(addr[13:12]);
    if (idx >= NP)          begin resp_exp = 2'b11; lat_exp = 1;     stb_exp = 0;     end
    else if (strb != 4'hF)  begin resp_exp = 2'b10; lat_exp = 1;     stb_exp = 0;     end
    else if (dly >= T)      begin resp_exp = 2'b10; lat_exp = 1 + T; stb_exp = T; exp_to++; end
    else                    begin resp_exp = 2'b00; lat_exp = 2 + dly; stb_exp = dly + 1; end
    exp_w = (idx < NP) ? NP'(1 << idx) : '0;
    exp_r = '0;
    if (idx < NP) dly_w[idx] = dly;
    g0 = stb_good; b0 = stb_bad;
    @(posedge clk); #1;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
    chk("w_accept_lat", n, 1);
    chk("w_wready", wready, 1'b1);
    t0 = cyc;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("w_ready_pulse", {awready, wready}, 2'b00);
    n = 0;
    while (!bvalid && n < T + 20) begin @(posedge clk); #1; n++; end
    chk("w_bvalid_lat", cyc - t0, lat_exp);
    chk("w_bresp", bresp, resp_exp);
    chk("w_strobe_cycles", stb_good - g0, stb_exp);
    chk("w_strobe_wrong", stb_bad - b0, 0);
    chk("w_waddr", port_waddr, addr[13:2]);
    chk("w_din", port_din, data);
    chk("w_tocnt", timeout_count, exp_to);
    r0 = bresp; stable = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!bvalid || bresp !== r0) stable = 1'b0;
    end
    chk("w_b_stable", stable, 1'b1);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("w_bvalid_drop", bvalid, 1'b0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int dly, input int hold);
    int idx, g0, b0, n, t0, lat_exp, stb_exp;
    logic [1:0] resp_exp, r0;
    logic [31:0] data_exp, d0;
    logic stable;
    idx = int'(addr[13:12]);
    data_exp = '0;
    if (idx >= NP)     begin resp_exp = 2'b11; lat_exp = 1;     stb_exp = 0; end
    else if (dly >= T) begin resp_exp = 2'b10; lat_exp = 1 + T; stb_exp = T; exp_to++; data_exp = 32'hDEAD_DEAD; end
    else               begin resp_exp = 2'b00; lat_exp = 2 + dly; stb_exp = dly + 1; data_exp = dout_mem[idx]; end
    exp_r = (idx < NP) ? NP'(1 << idx) : '0;
    exp_w = '0;
    if (idx < NP) dly_r[idx] = dly;
    g0 = stb_good; b0 = stb_bad;
    @(posedge clk); #1;
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!arready && n < 20);
    chk("r_accept_lat", n, 1);
    t0 = cyc;
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("r_ready_pulse", arready, 1'b0);
    n = 0;
    while (!rvalid && n < T + 20) begin @(posedge clk); #1; n++; end
    chk("r_rvalid_lat", cyc - t0, lat_exp);
    chk("r_rresp", rresp, resp_exp);
    if (idx < NP) chk("r_rdata", rdata, data_exp);
    chk("r_strobe_cycles", stb_good - g0, stb_exp);
    chk("r_strobe_wrong", stb_bad - b0, 0);
    chk("r_raddr", port_raddr, addr[13:2]);
    chk("r_tocnt", timeout_count, exp_to);
    r0 = rresp; d0 = rdata; stable = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!rvalid || rresp !== r0 || rdata !== d0) stable = 1'b0;
    end
    chk("r_stable", stable, 1'b1);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("r_rvalid_drop", rvalid, 1'b0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, na;
    logic [31:0] ord;
    for (int k = 0; k < NP; k++) begin
      dly_w[k] = 0; dly_r[k] = 0; dout_mem[k] = $urandom;
    end

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readies", {arready, awready, wready}, 3'b000);
    chk("rst_valids", {rvalid, bvalid}, 2'b00);
    chk("rst_strobes", {port_wstr, port_rstr}, '0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_resps", {rresp, bresp}, 4'h0);
    chk("rst_addrs", {port_waddr, port_raddr}, 24'h0);
    chk("rst_din", port_din, 32'h0);
    chk("rst_tocnt", timeout_count, 16'h0);

    // All valids held high across reset release: arbitration must alternate W,R,W,R
    awaddr = 32'h0000_0000; wdata = 32'h0BAD_F00D; wstrb = 4'hF; araddr = 32'h0000_1004;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("no_early_accept", {awready, arready}, 2'b00);
    ord = '0; na = 0; n = 0;
    while (na < 4 && n < 100) begin
      if (awready) begin ord = {ord[23:0], 8'h57}; na++; end
      else if (arready) begin ord = {ord[23:0], 8'h52}; na++; end
      if (na < 4) begin @(posedge clk); #1; n++; end
    end
    chk("arb_order", ord, 32'h5752_5752);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    bready = 1'b0; rready = 1'b0;
    chk("arb_drained", {rvalid, bvalid}, 2'b00);

    // Directed cases
    do_write(32'h0000_0810, 32'h1234_5678, 4'hF, 0, 0);
    dout_mem[2] = 32'hCAFE_F00D;
    do_read(32'h0000_0808, 5, 0);
    do_write(32'h0000_0010, 32'h5555_AAAA, 4'h3, 0, 1);
    do_read(32'h0000_0C08, 0, 0);
    do_write(32'h0000_3000, 32'h1111_2222, 4'hF, 0, 0);
    do_read(32'h0000_1000, NEVER, 0);
    do_write(32'h0000_1FFC, 32'h7777_8888, 4'hF, NEVER, 2);
    do_read(32'h0000_0004, 0, 10);

    // Reset while a read strobe is active
    dly_r[0] = NEVER;
    @(posedge clk); #1;
    araddr = 32'h0000_0020; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!arready && n < 20);
    @(posedge clk); #1;
    arvalid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid_stb_before", port_rstr, 3'b001);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("rst_mid_stb_drop", port_rstr, 3'b000);
    chk("rst_mid_rvalid", rvalid, 1'b0);
    chk("rst_mid_tocnt", timeout_count, 16'h0);
    exp_to = 0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    dout_mem[0] = 32'h600D_BEEF;
    do_read(32'h0000_0020, 2, 3);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      int dl, r, h, ix;
      a = $urandom; d = $urandom; r = $urandom_range(0, 9); h = $urandom_range(0, 3);
      dl = (r < 4) ? 0 : (r < 8) ? $urandom_range(1, 6) : (r == 8) ? NEVER : 2;
      ix = int'(a[13:12]);
      if ($urandom_range(0, 1) == 1) begin
        s = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
        do_write(a, d, s, dl, h);
      end else begin
        if (ix < NP) dout_mem[ix] = $urandom;
        do_read(a, dl, h);
      end
    end

    chk("final_tocnt", timeout_count, exp_to);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
